imem_stream_loader: RTL and testbench
=====================================

// Module: imem_stream_loader
// PURPOSE
//  Writer side of the instruction-memory load port (InstrWrite/WriteInst/WriteAdress).
//  Accepts a byte stream (valid/ready), assembles little-endian 32-bit words, and writes them
//  sequentially into imemory. Holds the pipelined core in reset until the image is loaded.
//  Sits beside top; its outputs drive the top-level InstrWrite/WriteInst/WriteAdress inputs.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of the first word written
//  DEPTH_WORDS  256            imemory capacity in words; a header count above this is an error
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  rx_valid     in   1   rx_data holds a valid byte
//  rx_data      in   8   stream byte
//  rx_ready     out  1   loader can accept a byte this cycle
//  reload       in   1   one-cycle pulse; restarts a load from DONE or ERR
//  InstrWrite   out  1   one-cycle write strobe to imemory
//  WriteInst    out  32  word to write, valid while InstrWrite=1
//  WriteAdress  out  32  byte address of the word, valid while InstrWrite=1
//  core_reset   out  1   held high to keep the core in reset during load
//  done         out  1   image loaded (and checked); level
//  error        out  1   load aborted; level
// BEHAVIOUR
//  - Byte transfer occurs on a cycle with rx_valid & rx_ready. No other cycle changes the byte counters.
//  - Frame: 4-byte LE word count N, then 4*N payload bytes (LE words), then a checksum if enabled.
//  - States: HDR -> DATA -> (CHK) -> DONE; any state may go -> ERR. Reset enters HDR.
//  - HDR: collect 4 bytes into N. On the 4th byte: N > DEPTH_WORDS -> ERR; N == 0 -> CHK or DONE;
//    otherwise -> DATA with word index i=0.
//  - DATA: on each 4th byte, InstrWrite=1 for exactly the next cycle with WriteInst = assembled word
//    and WriteAdress = BASE_ADDR + 4*i (mod 2^32). Then i++. After word N-1 -> CHK or DONE.
//  - Write latency: 1 cycle after the accepting edge of the word's last byte. Back-to-back words
//    with no rx gaps produce a strobe every 4 cycles.
//  - rx_ready = 1 in HDR/DATA/CHK, 0 in DONE/ERR and in reset. rx_valid is ignored when rx_ready=0.
//  - core_reset = 1 in every state except DONE; it deasserts on the cycle done rises.
//  - done=1 only in DONE; error=1 only in ERR; they are never both 1.
//  - reload in DONE or ERR: next state HDR, counters cleared, core_reset=1, done/error=0.
//    Ignored in HDR/DATA/CHK. A reload is not a transfer (no byte is consumed).
//  - reset mid-load: on the next edge, state=HDR and all counters clear. A partial word is discarded.
//    No InstrWrite pulse for the partial word.
//  - Reset values: rx_ready=0 during reset then 1; InstrWrite=0; WriteInst=0; WriteAdress=0;
//    core_reset=1; done=0; error=0.
//  - WriteInst/WriteAdress hold their last values when InstrWrite=0.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - After the payload, state CHK collects a 4-byte LE checksum C.
//   - Compare C with the mod-2^32 sum of all payload words; for N=0 the expected sum is 0.
//   - Match -> DONE; mismatch -> ERR. Words already written stay written.
//  Undefined: no CHK state; the frame ends after the payload and goes straight to DONE.
// TESTING
//  1) Load N=2, words 32'h0050_0093 and 32'h0000_006F, no gaps.
//     -> Strobes at 0x0 and 0x4 with those words; done=1; core_reset=0.
//  2) Header N=DEPTH_WORDS+1 (257). -> error=1, rx_ready=0, no InstrWrite, core_reset=1.
//  3) N=1 with rx_valid toggling every cycle.
//     -> Exactly one strobe, 1 cycle after the 4th accepted byte, correct word.
//  4) reset asserted after 2 payload bytes, then a fresh N=1 frame.
//     -> No strobe for the partial word; the new word is written at BASE_ADDR.
//  5) CHECKSUM_EN, N=2 words 1 and 2, C=3 -> done=1; repeat via reload with C=4 -> error=1.
//  6) N=0 (with CHECKSUM_EN: C=0) -> done=1 with no InstrWrite; then reload -> core_reset=1, state HDR.

Source files
------------

// File: rtl/imem_stream_loader_if.sv
// Byte-stream receive channel plus the imemory write port driven by the loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface imem_stream_loader_if;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_ready;
   logic              InstrWrite;
   logic [WORD_W-1:0] WriteInst;
   logic [WORD_W-1:0] WriteAdress;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, InstrWrite, WriteInst, WriteAdress
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, InstrWrite, WriteInst, WriteAdress
   );
endinterface

// File: rtl/imem_stream_loader.sv
// Loads a framed LE byte stream (count, payload words, optional checksum) into imemory
// and holds the core in reset until done. IMEM_LOADER_CHECKSUM_EN enables the checksum trailer.
module imem_stream_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reload,
   imem_stream_loader_if.slave  bus,
   output logic                 core_reset,
   output logic                 done,
   output logic                 error
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BCNT_W = 2;

   localparam logic [2:0] S_HDR  = 3'd0;
   localparam logic [2:0] S_DATA = 3'd1;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_END  = S_CHK;
`else
   localparam logic [2:0] S_END  = S_DONE;
`endif

   logic [2:0]        state_q, state_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] count_q, count_d;
   logic [WORD_W-1:0] idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [WORD_W-1:0] waddr_q, waddr_d;
   logic              ready_q, ready_d;
   logic              crst_q, crst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q, sum_d;
`endif

   logic              xfer_c;
   logic              last_byte_c;
   logic [WORD_W-1:0] word_c;

   // Bytes shift in from the top so the first byte ends up in bits [7:0].
   assign xfer_c      = bus.rx_valid & ready_q;
   assign last_byte_c = xfer_c && (bcnt_q == BCNT_W'(3));
   assign word_c      = {bus.rx_data, shift_q[WORD_W-1:8]};

   // Next-state and output decode
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      count_d = count_q;
      idx_d   = idx_q;
      wr_d    = 1'b0;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif

      if (xfer_c) begin
         shift_d = word_c;
         bcnt_d  = bcnt_q + BCNT_W'(1);
      end

      case (state_q)
         S_HDR: begin
            if (last_byte_c) begin
               if (word_c > WORD_W'(DEPTH_WORDS)) begin
                  state_d = S_ERR;
               end else if (word_c == '0) begin
                  state_d = S_END;
               end else begin
                  state_d = S_DATA;
                  count_d = word_c;
                  idx_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (last_byte_c) begin
               wr_d    = 1'b1;
               wdata_d = word_c;
               waddr_d = BASE_ADDR + {idx_q[WORD_W-3:0], 2'b00};
               idx_d   = idx_q + WORD_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + word_c;
`endif
               if (idx_q == count_q - WORD_W'(1)) begin
                  state_d = S_END;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (last_byte_c) begin
               state_d = (word_c == sum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (reload) begin
               state_d = S_HDR;
               bcnt_d  = '0;
               shift_d = '0;
               count_d = '0;
               idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         default: state_d = S_HDR;
      endcase

      // Status outputs are registered copies of the decoded next state.
      ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                || (state_d == S_CHK)
`endif
                ;
      crst_d  = (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
      err_d   = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_HDR;
         bcnt_q  <= '0;
         shift_q <= '0;
         count_q <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         waddr_q <= '0;
         ready_q <= 1'b0;
         crst_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         ready_q <= ready_d;
         crst_q  <= crst_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign bus.rx_ready    = ready_q;
   assign bus.InstrWrite  = wr_q;
   assign bus.WriteInst   = wdata_q;
   assign bus.WriteAdress = waddr_q;
   assign core_reset      = crst_q;
   assign done            = done_q;
   assign error           = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: expected writes are queued as bytes are
// accepted and matched against InstrWrite strobes (address, data, cycle).
module tb_imem_stream_loader;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   logic reset;
   logic reload;
   logic core_reset;
   logic done;
   logic error;

   imem_stream_loader_if bus();

   imem_stream_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .reload     (reload),
      .bus        (bus.slave),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int          widx;
   logic [31:0] csum;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h @cyc %0d", tag, act, exp, cyc);
      end
   endtask

   // Every strobe must match the oldest queued write, in the cycle after its last byte.
   always @(negedge clk) begin
      if (bus.InstrWrite === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_wr", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", bus.WriteAdress, e.addr);
            check("wr_data", bus.WriteInst, e.data);
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic send_byte(input logic [7:0] b, input bit gap, output int acc_cyc);
      bit ok;
      if (gap) begin
         bus.rx_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         ok = bus.rx_ready;
         @(posedge clk); #1;
      end
      acc_cyc = cyc;
      if (!ok) check("rx_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap, output int acc_cyc);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap, acc_cyc);
   endtask

   task automatic start_frame(input logic [31:0] n, input bit gap);
      int e;
      widx = 0;
      csum = '0;
      send_word(n, gap, e);
   endtask

   task automatic data_word(input logic [31:0] w, input bit gap);
      int  e;
      wr_t x;
      send_word(w, gap, e);
      x.addr = BASE + 32'(4 * widx);
      x.data = w;
      x.cyc  = e;
      sb.push_back(x);
      widx++;
      csum += w;
   endtask

   task automatic end_frame(input bit gap, input logic [31:0] cerr);
      int e;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(csum + cerr, gap, e);
`else
      e = 0;
      if (cerr != 0 || gap) e = 1;
`endif
      bus.rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 32'(bus.rx_ready), 32'd0);
      check("rst_wr", 32'(bus.InstrWrite), 32'd0);
      check("rst_crst", 32'(core_reset), 32'd1);
      check("rst_done_err", {30'd0, done, error}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(bus.rx_ready), 32'd1);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
      check("reload_ready", 32'(bus.rx_ready), 32'd1);
      check("reload_crst", 32'(core_reset), 32'd1);
      check("reload_done_err", {30'd0, done, error}, 32'd0);
   endtask

   task automatic expect_done(input string tag);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_err"}, 32'(error), 32'd0);
      check({tag, "_crst"}, 32'(core_reset), 32'd0);
      check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
   endtask

   initial begin
      int e;
      reset        = 1'b1;
      reload       = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      do_reset();
      check("rst_wdata", bus.WriteInst, 32'd0);
      check("rst_waddr", bus.WriteAdress, 32'd0);

      // Two words back-to-back
      start_frame(32'd2, 1'b0);
      data_word(32'h0050_0093, 1'b0);
      data_word(32'h0000_006F, 1'b0);
      end_frame(1'b0, 32'd0);
      expect_done("t1");
      check("t1_hold_data", bus.WriteInst, 32'h0000_006F);
      check("t1_hold_addr", bus.WriteAdress, BASE + 32'd4);

      // Oversized header
      do_reload();
      start_frame(32'(DEPTH + 1), 1'b0);
      bus.rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t2_err", 32'(error), 32'd1);
      check("t2_done", 32'(done), 32'd0);
      check("t2_ready", 32'(bus.rx_ready), 32'd0);
      check("t2_crst", 32'(core_reset), 32'd1);

      // Single word with rx_valid toggling
      do_reload();
      start_frame(32'd1, 1'b1);
      data_word(32'h1234_5678, 1'b1);
      end_frame(1'b1, 32'd0);
      expect_done("t3");

      // Reset after two payload bytes, then a fresh frame
      do_reload();
      start_frame(32'd1, 1'b0);
      send_byte(8'hEF, 1'b0, e);
      send_byte(8'hBE, 1'b0, e);
      do_reset();
      start_frame(32'd1, 1'b0);
      data_word(32'hDEAD_BEEF, 1'b0);
      end_frame(1'b0, 32'd0);
      expect_done("t4");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Good then bad checksum
      do_reload();
      start_frame(32'd2, 1'b0);
      data_word(32'd1, 1'b0);
      data_word(32'd2, 1'b0);
      end_frame(1'b0, 32'd0);
      expect_done("t5a");
      do_reload();
      start_frame(32'd2, 1'b0);
      data_word(32'd1, 1'b0);
      data_word(32'd2, 1'b0);
      end_frame(1'b0, 32'd1);
      check("t5b_err", 32'(error), 32'd1);
      check("t5b_done", 32'(done), 32'd0);
      check("t5b_crst", 32'(core_reset), 32'd1);
`endif

      // Empty image, then reload back to header
      do_reload();
      start_frame(32'd0, 1'b0);
      end_frame(1'b0, 32'd0);
      expect_done("t6");
      do_reload();

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
